// File: rtl/adam_aes_key_expand128.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry register file
// that drives the encipher's round_keys bus directly.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | ready=1, waiting for init; valid holds until init/zeroize
// ST_EXPAND | ready=0, rc=1..10 selects the round key written this edge
module adam_aes_key_expand128 (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         zeroize,
    input  logic [127:0] key,
    output logic         ready,
    output logic         valid,
    output logic [127:0] round_keys [0:10]
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    logic [0:0]   state;
    logic [3:0]   rc;
    logic [7:0]   rcon;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  t_word;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;

    // Outside rc=1..10 the step logic sees zero, so idle cycles never expose stale keys to the S-box.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (rc == 4'(i + 1)) begin
                prev_key = round_keys[i];
            end
        end
    end

    always_comb begin
        case (rc)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t_word   = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon, 24'h0};
    assign w0_n     = prev_key[127:96] ^ t_word;
    assign w1_n     = prev_key[95:64]  ^ w0_n;
    assign w2_n     = prev_key[63:32]  ^ w1_n;
    assign w3_n     = prev_key[31:0]   ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rc    <= 4'd0;
            ready <= 1'b1;
            valid <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                round_keys[i] <= '0;
            end
        end else if (zeroize) begin
            state <= ST_IDLE;
            rc    <= 4'd0;
            ready <= 1'b1;
            valid <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                round_keys[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        round_keys[0] <= key;
                        rc            <= 4'd1;
                        state         <= ST_EXPAND;
                        ready         <= 1'b0;
                        valid         <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (rc == 4'(i)) begin
                            round_keys[i] <= next_key;
                        end
                    end
                    rc <= rc + 4'd1;
                    if (rc == 4'd10) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adam_aes_key_expand128.sv
// Scoreboarded bench for adam_aes_key_expand128: expected schedules come from a word-oriented
// key expansion using an S-box derived from GF(2^8) inversion and the affine map.
module tb_adam_aes_key_expand128;

    typedef logic [10:0][127:0] sched_t;
    typedef struct {
        sched_t s;
        int     due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init;
    logic         zeroize;
    logic [127:0] key;
    logic         ready;
    logic         valid;
    logic [127:0] rk [0:10];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] sbox_m [0:255];

    adam_aes_key_expand128 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init       (init),
        .zeroize    (zeroize),
        .key        (key),
        .ready      (ready),
        .valid      (valid),
        .round_keys (rk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic sched_t model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp  = {tmp[23:0], tmp[31:24]};
                tmp  = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp  = tmp ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) s[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Accepts key on the next IDLE edge and queues its expected schedule.
    task automatic start_key(input logic [127:0] k, output int c);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) note_fail("wait_ready");
        init = 1'b1;
        key  = k;
        @(posedge clk);
        #1;
        c = cyc;
        sb.push_back('{s: model_expand(k), due: c + 10});
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!valid) note_fail("wait_valid");
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every rising edge of valid must match the oldest queued schedule, on time.
    initial begin
        logic vp;
        exp_t e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !vp) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got valid=1, expected no completion (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    for (int r = 0; r <= 10; r++) chk($sformatf("rk%0d", r), rk[r], e.s[r]);
                    chk("latency", 128'(cyc), 128'(e.due));
                end
            end
            vp = valid;
        end
    end

    initial begin
        int c;
        int n;
        reset_n = 1'b0;
        init    = 1'b0;
        zeroize = 1'b0;
        key     = '0;
        build_sbox();
        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_valid", 128'(valid), 128'(0));
        chk("reset_rk0", rk[0], '0);
        chk("reset_rk10", rk[10], '0);
        reset_n = 1'b1;
        @(negedge clk);

        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c, c);
        wait_done();
        chk("fips_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        start_key(128'h0, c);
        wait_done();
        chk("zero_rk1", rk[1], 128'h62636363626363636263636362636363);
        chk("zero_rk10", rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        start_key(128'h000102030405060708090a0b0c0d0e0f, c);
        wait_done();
        chk("count_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // init pulsed at E4 during expansion is dropped
        start_key({$urandom, $urandom, $urandom, $urandom}, c);
        wait_cyc(c + 3);
        init = 1'b1;
        key  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        init = 1'b0;
        chk("busy_ready", 128'(ready), 128'(0));
        wait_done();

        // init held high: back-to-back runs, valid high for one cycle between them
        @(negedge clk);
        init = 1'b1;
        key  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        c = cyc;
        sb.push_back('{s: model_expand(key), due: c + 10});
        @(negedge clk);
        key = {$urandom, $urandom, $urandom, $urandom};
        wait_cyc(c + 10);
        chk("held_valid_hi", 128'(valid), 128'(1));
        chk("held_ready_hi", 128'(ready), 128'(1));
        @(posedge clk);
        #1;
        sb.push_back('{s: model_expand(key), due: cyc + 10});
        @(negedge clk);
        init = 1'b0;
        chk("held_valid_lo", 128'(valid), 128'(0));
        wait_done();

        // zeroize at E6 with init in the same cycle
        start_key({$urandom, $urandom, $urandom, $urandom}, c);
        wait_cyc(c + 5);
        zeroize = 1'b1;
        init    = 1'b1;
        key     = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        @(negedge clk);
        zeroize = 1'b0;
        init    = 1'b0;
        for (int r = 0; r <= 10; r++) chk($sformatf("zeroize_rk%0d", r), rk[r], '0);
        chk("zeroize_valid", 128'(valid), 128'(0));
        chk("zeroize_ready", 128'(ready), 128'(1));
        repeat (3) @(negedge clk);
        chk("zeroize_no_start", 128'(ready), 128'(1));
        chk("zeroize_rk0_later", rk[0], '0);

        // zeroize while valid
        start_key({$urandom, $urandom, $urandom, $urandom}, c);
        wait_done();
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("zv_valid", 128'(valid), 128'(0));
        chk("zv_rk0", rk[0], '0);
        chk("zv_rk10", rk[10], '0);

        // asynchronous reset mid-expansion, then immediate restart
        start_key({$urandom, $urandom, $urandom, $urandom}, c);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_valid", 128'(valid), 128'(0));
        for (int r = 0; r <= 10; r++) chk($sformatf("rst_rk%0d", r), rk[r], '0);
        @(negedge clk);
        reset_n = 1'b1;
        init    = 1'b1;
        key     = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        chk("rst_accept", 128'(ready), 128'(0));
        sb.push_back('{s: model_expand(key), due: cyc + 10});
        @(negedge clk);
        init = 1'b0;
        wait_done();

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_key({$urandom, $urandom, $urandom, $urandom}, c);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) note_fail("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
